// File: rtl/rf_dump_pkg.sv
// Shared definitions for the register-file dump scanner: FSM state codes,
// ASCII constants, line lengths and the decimal index helpers.
package rf_dump_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_SEL    = 3'd1;
    localparam state_t S_LATCH  = 3'd2;
    localparam state_t S_PREFIX = 3'd3;
    localparam state_t S_HEX    = 3'd4;
    localparam state_t S_EOL    = 3'd5;
    localparam state_t S_DONE   = 3'd6;

    localparam logic [7:0] ASCII_R     = 8'h72;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A_OFS = 8'h37;  // 'A' - 10

    localparam int LINE_BYTES_PLAIN = 9;
    localparam int LINE_BYTES_INDEX = 13;

    function automatic logic [1:0] dec_tens(input logic [4:0] idx);
        if (idx >= 5'd30)      return 2'd3;
        else if (idx >= 5'd20) return 2'd2;
        else if (idx >= 5'd10) return 2'd1;
        else                   return 2'd0;
    endfunction

    function automatic logic [3:0] dec_units(input logic [4:0] idx);
        logic [4:0] rem;
        rem = idx - (5'(dec_tens(idx)) * 5'd10);
        return rem[3:0];
    endfunction

endpackage

// File: rtl/rf_dump_scanner_if.sv
// Byte stream from the dump scanner to the UART transmitter (valid/ready).
interface rf_dump_scanner_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/rf_dump_hex2ascii.sv
// Combinational nibble to uppercase ASCII hex digit converter.
module rf_dump_hex2ascii
    import rf_dump_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    always_comb begin
        if (nibble < 4'd10) ascii = ASCII_0 + {4'd0, nibble};
        else                ascii = ASCII_A_OFS + {4'd0, nibble};
    end
endmodule

// File: rtl/rf_dump_scanner.sv
// Walks the register-file debug port and streams each register as an ASCII hex line.
// Define RF_DUMP_INDEX_EN to prefix every line with "rNN=".
module rf_dump_scanner
    import rf_dump_pkg::*;
#(
    parameter int         FIRST_REG = 0,
    parameter int         LAST_REG  = 31,
    parameter logic [7:0] EOL_CHAR  = 8'h0A
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [4:0]                reg_sel,
    input  logic [31:0]               reg_data,
    rf_dump_scanner_if.master         tx,
    output logic                      busy,
    output logic                      done
);
    state_t      state_q, state_d;
    logic [4:0]  reg_sel_q, reg_sel_d;
    logic [31:0] snap_q, snap_d;
    logic [2:0]  nib_q, nib_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
`ifdef RF_DUMP_INDEX_EN
    logic [1:0]  pfx_q, pfx_d;
`endif

    logic        accept;
    logic [2:0]  hex_idx;
    logic [3:0]  hex_nib;
    logic [7:0]  hex_char;

    assign accept = tx_valid_q && tx.tx_ready;

    // Digit that will be presented next: MSB when a line starts, else one below the current.
    assign hex_idx = (state_q == S_HEX) ? (nib_q - 3'd1) : 3'd7;
    assign hex_nib = snap_q[{hex_idx, 2'b00} +: 4];

    rf_dump_hex2ascii u_hex2ascii (
        .nibble (hex_nib),
        .ascii  (hex_char)
    );

    always_comb begin
        state_d    = state_q;
        reg_sel_d  = reg_sel_q;
        snap_d     = snap_q;
        nib_d      = nib_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
`ifdef RF_DUMP_INDEX_EN
        pfx_d      = pfx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    reg_sel_d = 5'(FIRST_REG);
                    busy_d    = 1'b1;
                    state_d   = S_SEL;
                end
            end
            S_SEL: begin
                snap_d  = reg_data;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                nib_d      = 3'd7;
                tx_valid_d = 1'b1;
`ifdef RF_DUMP_INDEX_EN
                tx_data_d  = ASCII_R;
                pfx_d      = 2'd0;
                state_d    = S_PREFIX;
`else
                tx_data_d  = hex_char;
                state_d    = S_HEX;
`endif
            end
`ifdef RF_DUMP_INDEX_EN
            S_PREFIX: begin
                if (accept) begin
                    pfx_d = pfx_q + 2'd1;
                    case (pfx_q)
                        2'd0:    tx_data_d = ASCII_0 + {6'd0, dec_tens(reg_sel_q)};
                        2'd1:    tx_data_d = ASCII_0 + {4'd0, dec_units(reg_sel_q)};
                        2'd2:    tx_data_d = ASCII_EQ;
                        default: begin
                            tx_data_d = hex_char;
                            state_d   = S_HEX;
                        end
                    endcase
                end
            end
`endif
            S_HEX: begin
                if (accept) begin
                    if (nib_q == 3'd0) begin
                        tx_data_d = EOL_CHAR;
                        state_d   = S_EOL;
                    end else begin
                        nib_d     = nib_q - 3'd1;
                        tx_data_d = hex_char;
                    end
                end
            end
            S_EOL: begin
                if (accept) begin
                    tx_valid_d = 1'b0;
                    if (reg_sel_q == 5'(LAST_REG)) begin
                        state_d = S_DONE;
                    end else begin
                        reg_sel_d = reg_sel_q + 5'd1;
                        state_d   = S_SEL;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            reg_sel_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_sel_q  <= reg_sel_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

    // Datapath registers carry no reset; they are only observed in states that load them first.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
        nib_q  <= nib_d;
`ifdef RF_DUMP_INDEX_EN
        pfx_q  <= pfx_d;
`endif
    end

    assign reg_sel     = reg_sel_q;
    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy        = busy_q;
    assign done        = (state_q == S_DONE);

endmodule
